// File: rtl/stdp_learning_engine.sv
// Trace-based STDP learner over an N x N signed weight array: potentiates pre-before-post,
// depresses post-before-pre, one ordered pair per cycle after each enabled timestep strobe.
module stdp_learning_engine #(
  parameter int unsigned N         = 7,
  parameter int unsigned W_BITS    = 8,
  parameter int unsigned TRACE_MAX = 3,
  parameter int unsigned A_PLUS    = 2,
  parameter int unsigned A_MINUS   = 1,
  localparam int unsigned IW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic [N-1:0]      spikes,
  input  logic              learning_enable,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_i,
  input  logic [IW-1:0]     wr_j,
  input  logic [W_BITS-1:0] wr_data,
  input  logic [IW-1:0]     rd_i,
  input  logic [IW-1:0]     rd_j,
  output logic [W_BITS-1:0] rd_data,
  output logic              busy,
  output logic              scan_done,
  output logic              overrun,
  input  logic              clr_overrun,
  output logic [15:0]       last_weight
);

  localparam int unsigned TW = $clog2(TRACE_MAX + 1);
  localparam int unsigned WS = W_BITS + 2;
  localparam logic signed [WS-1:0] SAT_MAX = WS'((2 ** (W_BITS - 1)) - 1);
  localparam logic signed [WS-1:0] SAT_MIN = WS'(-(2 ** (W_BITS - 1)));
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW:0]   N_EXT = (IW + 1)'(N);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state, state_d;
  logic busy_d, scan_done_d, launch_c, last_pair_c;

  logic signed [W_BITS-1:0] w [N][N];
  logic [TW-1:0] trace [N];
  logic [TW-1:0] snap_tr [N];
  logic [N-1:0]  snap_sp;
  logic [IW-1:0] pi, pj;

  logic                     pot_c, dep_c, chg_c, wr_ok_c, rd_ok_c;
  logic signed [WS-1:0]     sum_c;
  logic signed [W_BITS-1:0] w_cur_c, w_new_c;

  assign last_pair_c = (pi == LAST) && (pj == LAST);
  assign wr_ok_c     = ({1'b0, wr_i} < N_EXT) && ({1'b0, wr_j} < N_EXT);
  assign rd_ok_c     = ({1'b0, rd_i} < N_EXT) && ({1'b0, rd_j} < N_EXT);

  // Pair update: widened sum so the saturating clamp sees the true value
  always_comb begin
    w_cur_c = w[pi][pj];
    pot_c   = snap_sp[pj] && (snap_tr[pi] != '0);
    dep_c   = snap_sp[pi] && (snap_tr[pj] != '0);
    sum_c   = WS'(w_cur_c);
    if (pot_c) sum_c = sum_c + WS'(A_PLUS);
    if (dep_c) sum_c = sum_c - WS'(A_MINUS);
    if (sum_c > SAT_MAX)      w_new_c = SAT_MAX[W_BITS-1:0];
    else if (sum_c < SAT_MIN) w_new_c = SAT_MIN[W_BITS-1:0];
    else                      w_new_c = W_BITS'(sum_c);
    chg_c = (pi != pj) && (w_new_c != w_cur_c);
  end

  always_comb begin
    state_d     = state;
    busy_d      = 1'b0;
    scan_done_d = 1'b0;
    launch_c    = 1'b0;
    case (state)
      IDLE: begin
        if (step && learning_enable) begin
          launch_c = 1'b1;
          busy_d   = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (last_pair_c) begin
          busy_d      = 1'b0;
          scan_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      scan_done <= 1'b0;
      pi        <= '0;
      pj        <= '0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      scan_done <= scan_done_d;
      if (launch_c) begin
        pi <= '0;
        pj <= '0;
      end else if (state == SCAN) begin
        if (pj == LAST) begin
          pj <= '0;
          pi <= pi + 1'b1;
        end else begin
          pj <= pj + 1'b1;
        end
      end
    end
  end

  // Traces run on every strobe; the snapshot freezes pre-update values for the scan
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_sp <= '0;
      for (int k = 0; k < N; k++) begin
        trace[k]   <= '0;
        snap_tr[k] <= '0;
      end
    end else begin
      if (launch_c) begin
        snap_sp <= spikes;
        for (int k = 0; k < N; k++) snap_tr[k] <= trace[k];
      end
      if (step) begin
        for (int k = 0; k < N; k++) begin
          if (spikes[k])           trace[k] <= TW'(TRACE_MAX);
          else if (trace[k] != '0) trace[k] <= trace[k] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_weight <= '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) w[i][j] <= '0;
    end else if (state == SCAN) begin
      if (chg_c) begin
        w[pi][pj]   <= w_new_c;
        last_weight <= 16'(w_new_c);
      end
    end else if (wr_en && wr_ok_c) begin
      w[wr_i][wr_j] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      overrun <= 1'b0;
    end else begin
      rd_data <= rd_ok_c ? w[rd_i][rd_j] : '0;
      if (step && busy)     overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stdp_learning_engine.sv
// Directed bench for stdp_learning_engine (N=4, W_BITS=8, TRACE_MAX=3, A_PLUS=2, A_MINUS=1).
module tb_stdp_learning_engine;

  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset, step, learning_enable, wr_en, clr_overrun;
  logic [3:0]    spikes;
  logic [IW-1:0] wr_i, wr_j, rd_i, rd_j;
  logic [7:0]    wr_data, rd_data;
  logic          busy, scan_done, overrun;
  logic [15:0]   last_weight;

  int tests = 0;
  int failures = 0;

  stdp_learning_engine #(
    .N(4), .W_BITS(8), .TRACE_MAX(3), .A_PLUS(2), .A_MINUS(1)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .spikes(spikes),
    .learning_enable(learning_enable), .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j),
    .wr_data(wr_data), .rd_i(rd_i), .rd_j(rd_j), .rd_data(rd_data), .busy(busy),
    .scan_done(scan_done), .overrun(overrun), .clr_overrun(clr_overrun),
    .last_weight(last_weight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input int i, input int j, input logic [7:0] exp);
    rd_i = IW'(i);
    rd_j = IW'(j);
    @(negedge clk);
    check(tag, {8'h00, rd_data}, {8'h00, exp});
  endtask

  task automatic wr_w(input int i, input int j, input logic [7:0] d);
    wr_i = IW'(i);
    wr_j = IW'(j);
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One strobe, then 20 cycles observing busy and scan_done
  task automatic do_step(input string tag, input logic [3:0] sp, input logic en);
    int nb, nd;
    spikes = sp;
    learning_enable = en;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    spikes = '0;
    nb = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy) nb++;
      if (scan_done) nd++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 16'(nb), en ? 16'd16 : 16'd0);
    check({tag, "_done_pulses"}, 16'(nd), en ? 16'd1 : 16'd0);
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) do_step("flush", 4'b0000, 1'b0);
  endtask

  initial begin
    int nd;
    reset = 1'b1;
    step = 1'b0; learning_enable = 1'b0; wr_en = 1'b0; clr_overrun = 1'b0;
    spikes = '0; wr_i = '0; wr_j = '0; wr_data = '0; rd_i = '0; rd_j = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, scan_done}, 16'd0);
    check("rst_overrun", {15'd0, overrun}, 16'd0);
    check("rst_last_weight", last_weight, 16'h0000);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) check_w("rst_weight", i, j, 8'h00);

    // Reset mid-scan aborts
    spikes = 4'b1111; learning_enable = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0; spikes = '0;
    repeat (3) @(negedge clk);
    check("midscan_busy_before", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midscan_busy_after_reset", {15'd0, busy}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midscan_busy_after_release", {15'd0, busy}, 16'd0);

    // Basic pre-before-post pair
    do_step("pair_a", 4'b0001, 1'b1);
    do_step("pair_b", 4'b0010, 1'b1);
    check_w("pair_w01", 0, 1, 8'h02);
    check_w("pair_w10", 1, 0, 8'hFF);
    check_w("pair_w00", 0, 0, 8'h00);
    check_w("pair_w12", 1, 2, 8'h00);
    check_w("pair_w21", 2, 1, 8'h00);
    check_w("pair_w23", 2, 3, 8'h00);
    check("pair_last_weight", last_weight, 16'hFFFF);

    // Read in the same cycle as a write returns the old value
    flush();
    rd_i = 2'd3; rd_j = 2'd3;
    wr_w(3, 3, 8'h09);
    check("rw_old", {8'h00, rd_data}, 16'h0000);
    @(negedge clk);
    check("rw_new", {8'h00, rd_data}, 16'h0009);
    wr_w(3, 3, 8'h00);

    // Saturation at both rails
    wr_w(0, 1, 8'h7E);
    wr_w(1, 0, 8'h80);
    do_step("sat_a", 4'b0001, 1'b1);
    do_step("sat_b", 4'b0010, 1'b1);
    check_w("sat_w01", 0, 1, 8'h7F);
    check_w("sat_w10", 1, 0, 8'h80);
    check("sat_last_weight", last_weight, 16'h007F);

    // Trace still live after two empty steps
    flush();
    wr_w(0, 1, 8'h00);
    wr_w(1, 0, 8'h00);
    do_step("decay2_a", 4'b0001, 1'b1);
    do_step("decay2_e1", 4'b0000, 1'b1);
    do_step("decay2_e2", 4'b0000, 1'b1);
    do_step("decay2_b", 4'b0010, 1'b1);
    check_w("decay2_w01", 0, 1, 8'h02);
    check_w("decay2_w10", 1, 0, 8'hFF);

    // Trace expired after three empty steps
    flush();
    wr_w(0, 1, 8'h00);
    wr_w(1, 0, 8'h00);
    do_step("decay3_a", 4'b0001, 1'b1);
    for (int k = 0; k < 3; k++) do_step("decay3_e", 4'b0000, 1'b1);
    do_step("decay3_b", 4'b0010, 1'b1);
    check_w("decay3_w01", 0, 1, 8'h00);
    check_w("decay3_w10", 1, 0, 8'h00);

    // Step and host write while busy
    flush();
    spikes = 4'b0000; learning_enable = 1'b1; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    nd = 0;
    for (int c = 0; c < 25; c++) begin
      if (c == 4) begin
        step = 1'b1; wr_en = 1'b1; wr_i = 2'd2; wr_j = 2'd2; wr_data = 8'h37;
      end else begin
        step = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
      if (scan_done) nd++;
    end
    check("ovr_set", {15'd0, overrun}, 16'd1);
    check("ovr_single_done", 16'(nd), 16'd1);
    check_w("ovr_write_ignored", 2, 2, 8'h00);
    check("ovr_sticky", {15'd0, overrun}, 16'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovr_cleared", {15'd0, overrun}, 16'd0);

    // Learning disabled: no scans, traces keep running
    flush();
    do_step("le0_a", 4'b0001, 1'b0);
    do_step("le0_b", 4'b0010, 1'b0);
    check_w("le0_w01", 0, 1, 8'h00);
    check_w("le0_w10", 1, 0, 8'h00);
    do_step("le1_c", 4'b0001, 1'b1);
    check_w("le1_w01", 0, 1, 8'hFF);
    check_w("le1_w10", 1, 0, 8'h02);
    check("le1_last_weight", last_weight, 16'h0002);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
